// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_PEND = 2'd1,
    IC_DONE = 2'd2,
    IC_RSVD = 2'd3
  } ic_status_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fq_entry_t                i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output fq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_doPop;
  logic w_doPush;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_doPop  = i_pop & ~w_empty;
  // A push into a full queue is still accepted when the head leaves in the same cycle.
  assign w_doPush = i_push & (~w_full | w_doPop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_doPush && !w_doPop)      r_count <= r_count + 1'b1;
      else if (w_doPop && !w_doPush) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  assign o_valid = ~w_empty;
  assign o_head  = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule

// File: rtl/fetch_unit.sv
// L1 I-cache fetch initiator: owns the PC, drives address/stall and fills the fetch queue.
// Optional statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_en,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic [31:0]                 ic_addr,
  output logic                        ic_stall,
  input  logic [31:0]                 ic_r_data,
  input  logic [1:0]                  ic_r_data_status,
  output logic                        fq_valid,
  input  logic                        fq_ready,
  output logic [31:0]                 fq_pc,
  output logic [31:0]                 fq_instr,
`ifdef FETCH_STATS_EN
  output logic [31:0]                 fetched_count,
  output logic [31:0]                 fq_full_stall_count,
`endif
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  logic [31:0] r_pc;
  logic        w_idle;
  logic        w_push;
  logic        w_full;
  fq_entry_t   w_pushData;
  fq_entry_t   w_head;

  assign w_idle = (ic_r_data_status == IC_IDLE);
  // Redirect wins over a completing access; its data is stale.
  assign w_push = (ic_r_data_status == IC_DONE) & ~redirect_valid;

  assign ic_stall = redirect_valid | (w_idle & (~fetch_en | w_full));
  assign ic_addr  = r_pc;

  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= alignPc(redirect_pc);
    else if (w_push)         r_pc <= r_pc + PC_STEP;
  end

  assign w_pushData = '{pc: r_pc, instr: ic_r_data};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_pushData),
    .i_pop   (fq_ready),
    .o_valid (fq_valid),
    .o_head  (w_head),
    .o_count (fq_count),
    .o_full  (w_full)
  );

  assign fq_pc    = w_head.pc;
  assign fq_instr = w_head.instr;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetchedCount;
  logic [31:0] r_fullStallCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchedCount   <= '0;
      r_fullStallCount <= '0;
    end else begin
      if (w_push) r_fetchedCount <= r_fetchedCount + 32'd1;
      if (w_idle && w_full && fetch_en) r_fullStallCount <= r_fullStallCount + 32'd1;
    end
  end

  assign fetched_count       = r_fetchedCount;
  assign fq_full_stall_count = r_fullStallCount;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cache responder plus a queue-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RST_PC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ic_addr;
  logic        ic_stall;
  logic [31:0] ic_r_data;
  logic [1:0]  cStatus;
  logic        fq_valid;
  logic        fq_ready;
  logic [31:0] fq_pc;
  logic [31:0] fq_instr;
  logic [2:0]  fq_count;
`ifdef FETCH_STATS_EN
  logic [31:0] fetched_count;
  logic [31:0] fq_full_stall_count;
`endif

  fetch_unit #(
    .RESET_PC (RST_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_en            (fetch_en),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .ic_addr             (ic_addr),
    .ic_stall            (ic_stall),
    .ic_r_data           (ic_r_data),
    .ic_r_data_status    (cStatus),
    .fq_valid            (fq_valid),
    .fq_ready            (fq_ready),
    .fq_pc               (fq_pc),
    .fq_instr            (fq_instr),
`ifdef FETCH_STATS_EN
    .fetched_count       (fetched_count),
    .fq_full_stall_count (fq_full_stall_count),
`endif
    .fq_count            (fq_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  fq_entry_t   refQ[$];
  logic [31:0] refPc;
  logic [31:0] refFetched;
  logic [31:0] refFullStall;
  logic [63:0] obsPop[$];
  int          obsPopStep[$];
  int          stepNo;

  int          hitLat;
  int          cCnt;
  logic [31:0] cAddr;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance model and cache.
  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fq_entry_t head;
    logic      expStall;
    logic      full;
    logic [1:0] nS;
    fetch_en       = fe;
    fq_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    full     = (refQ.size() == FQ_DEPTH);
    expStall = rv | ((cStatus == 2'd0) & (~fe | full));
    head     = (refQ.size() != 0) ? refQ[0] : '0;
    checkOutput("ic_stall", 64'(ic_stall), 64'(expStall));
    checkOutput("ic_addr",  64'(ic_addr),  64'(refPc));
    checkOutput("fq_count", 64'(fq_count), 64'(refQ.size()));
    checkOutput("fq_valid", 64'(fq_valid), 64'(refQ.size() != 0));
    checkOutput("fq_head",  {fq_pc, fq_instr}, head);
    if (cStatus == 2'd2) checkOutput("addr_hold", 64'(ic_addr), 64'(cAddr));
`ifdef FETCH_STATS_EN
    checkOutput("fetched_count", 64'(fetched_count), 64'(refFetched));
    checkOutput("full_stall_count", 64'(fq_full_stall_count), 64'(refFullStall));
`endif
    if (rdy && fq_valid) begin
      obsPop.push_back({fq_pc, fq_instr});
      obsPopStep.push_back(stepNo);
    end
    if (cStatus == 2'd0 && full && fe) refFullStall++;
    if (rdy && refQ.size() != 0) void'(refQ.pop_front());
    if (rv) begin
      refQ.delete();
      refPc = rpc & ~32'd3;
    end else if (cStatus == 2'd2) begin
      refQ.push_back('{pc: refPc, instr: memData(refPc)});
      refPc = refPc + 32'd4;
      refFetched++;
    end
    nS = 2'd0;
    if (!expStall) begin
      case (cStatus)
        2'd0: begin nS = 2'd1; cCnt = hitLat + 1; cAddr = refPc; end
        2'd1: begin
          if (cCnt <= 1) nS = 2'd2;
          else begin nS = 2'd1; cCnt--; end
        end
        default: nS = 2'd0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    cStatus   = nS;
    ic_r_data = (nS == 2'd2) ? memData(cAddr) : $urandom;
    stepNo++;
  endtask

  task automatic applyReset();
    rst            = 1'b1;
    fetch_en       = 1'b0;
    fq_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    cStatus      = 2'd0;
    ic_r_data    = $urandom;
    refQ.delete();
    refPc        = RST_PC;
    refFetched   = '0;
    refFullStall = '0;
    stepNo       = 0;
    obsPop.delete();
    obsPopStep.delete();
    checkOutput("rst_addr",  64'(ic_addr),  64'(RST_PC));
    checkOutput("rst_count", 64'(fq_count), 64'd0);
    checkOutput("rst_valid", 64'(fq_valid), 64'd0);
    checkOutput("rst_head",  {fq_pc, fq_instr}, 64'd0);
`ifdef FETCH_STATS_EN
    checkOutput("rst_fetched", 64'(fetched_count), 64'd0);
    checkOutput("rst_fullstall", 64'(fq_full_stall_count), 64'd0);
`endif
  endtask

  initial begin
    logic [31:0] a0;
    int          n0;
    cStatus   = 2'd0;
    ic_r_data = '0;
    hitLat    = 1;
    cCnt      = 0;
    cAddr     = '0;

    // Streaming at hit latency 1: one instruction every 4 cycles.
    applyReset();
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t1_npop", 64'(obsPop.size()), 64'd3);
    if (obsPop.size() >= 3) begin
      checkOutput("t1_pop0", obsPop[0], {32'hBFC0_0000, memData(32'hBFC0_0000)});
      checkOutput("t1_pop1", obsPop[1], {32'hBFC0_0004, memData(32'hBFC0_0004)});
      checkOutput("t1_pop2", obsPop[2], {32'hBFC0_0008, memData(32'hBFC0_0008)});
      checkOutput("t1_first", 64'(obsPopStep[0]), 64'd4);
      checkOutput("t1_gap1", 64'(obsPopStep[1] - obsPopStep[0]), 64'd4);
      checkOutput("t1_gap2", 64'(obsPopStep[2] - obsPopStep[1]), 64'd4);
    end

    // Back-pressure fills the queue, then fetch resumes without loss.
    applyReset();
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t2_count", 64'(fq_count), 64'd4);
    checkOutput("t2_addr",  64'(ic_addr),  64'h0000_0000_BFC0_0010);
    checkOutput("t2_stall", 64'(ic_stall), 64'd1);
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t2_npop", 64'(obsPop.size() >= 5), 64'd1);
    if (obsPop.size() >= 5) begin
      checkOutput("t2_pop3", obsPop[3], {32'hBFC0_000C, memData(32'hBFC0_000C)});
      checkOutput("t2_pop4", obsPop[4], {32'hBFC0_0010, memData(32'hBFC0_0010)});
    end

    // Redirect while an access is pending with two entries queued.
    applyReset();
    for (int i = 0; i < 100 && !(refQ.size() == 2 && cStatus == 2'd1); i++)
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t3_reach", 64'(refQ.size() == 2 && cStatus == 2'd1), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h8000_0103);
    checkOutput("t3_count", 64'(fq_count), 64'd0);
    checkOutput("t3_addr",  64'(ic_addr),  64'h0000_0000_8000_0100);
    obsPop.delete();
    for (int i = 0; i < 50 && obsPop.size() == 0; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t3_npop", 64'(obsPop.size() != 0), 64'd1);
    if (obsPop.size() != 0) checkOutput("t3_pc", 64'(obsPop[0][63:32]), 64'h0000_0000_8000_0100);

    // Redirect coinciding with data-valid discards the stale data.
    for (int i = 0; i < 50 && cStatus != 2'd2; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t4_reach", 64'(cStatus), 64'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1000);
    checkOutput("t4_addr",  64'(ic_addr),  64'h0000_0000_0000_1000);
    checkOutput("t4_count", 64'(fq_count), 64'd0);
    obsPop.delete();
    for (int i = 0; i < 50 && obsPop.size() == 0; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t4_npop", 64'(obsPop.size() != 0), 64'd1);
    if (obsPop.size() != 0) checkOutput("t4_pc", 64'(obsPop[0][63:32]), 64'h0000_0000_0000_1000);

    // fetch_en drops mid-access: the access completes, then the cache is held idle.
    applyReset();
    for (int i = 0; i < 50 && !(cStatus == 2'd1 && refQ.size() == 1); i++)
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
    a0 = refPc;
    n0 = refQ.size();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("t5_count", 64'(fq_count), 64'(n0 + 1));
    checkOutput("t5_addr",  64'(ic_addr),  64'(a0 + 32'd4));
    checkOutput("t5_stall", 64'(ic_stall), 64'd1);
    obsPop.delete();
    for (int i = 0; i < 60 && obsPop.size() < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t5_npop", 64'(obsPop.size() >= 3), 64'd1);
    if (obsPop.size() >= 3) checkOutput("t5_resume", 64'(obsPop[2][63:32]), 64'(a0 + 32'd4));

    // Pop and push together at data-valid with three queued: occupancy holds, order kept.
    applyReset();
    for (int i = 0; i < 50 && !(cStatus == 2'd2 && refQ.size() == 3); i++)
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("t6_count", 64'(fq_count), 64'd3);
    checkOutput("t6_head",  64'(fq_pc),    64'h0000_0000_BFC0_0004);
`ifdef FETCH_STATS_EN
    checkOutput("t6_fetched", 64'(fetched_count), 64'd4);
`endif
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t6_full", 64'(fq_count), 64'd4);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    // Randomised traffic with redirects, enable toggling, varying latency and resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) applyReset();
      hitLat = $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 24) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
